// File: rtl/alu_result_buffer.sv
// ---------------------------------------------------------------------------
// alu_result_buffer
//
// Purpose:
//   Two-entry FIFO that decouples an ALU from its consumer. Each entry holds
//   the ALU result word, the upper multiply half and the flag vector. The
//   block also keeps a sticky OR of the flags of every accepted word, and can
//   optionally check the parity flag of each accepted word against the
//   result it arrived with.
//
// Parameters:
//   DATA_W  width of the result and upper-result words (default 64)
//   FLAG_W  flag vector width (default 7): carry[0], overflow[1], zero[2],
//           negative[3], parity[4], modulo[5], sign[6]
//
// Ports:
//   clk           rising-edge clock for all state
//   rst_n         synchronous active-low reset
//   in_valid      upstream word valid
//   in_ready      buffer can accept a word (count != 2)
//   in_result     ALU result
//   in_upper      ALU upper multiply half
//   in_flags      ALU flags
//   out_valid     head entry valid (count != 0)
//   out_ready     consumer accepts the head entry
//   out_result    head entry result
//   out_upper     head entry upper half
//   out_flags     head entry flags
//   sticky_flags  OR of flags of all words accepted since the last clear
//   sticky_clr    clears sticky_flags
//   count         occupancy, 0..2
//   par_err       sticky parity-check error
//
// Configuration macro:
//   ALU_RB_PARITY_CHK_EN  when defined, every accepted word has its parity
//                         flag compared against ~^in_result; a mismatch sets
//                         par_err until reset. When undefined, par_err is 0.
// ---------------------------------------------------------------------------
module alu_result_buffer #(
    parameter int DATA_W = 64,
    parameter int FLAG_W = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic [DATA_W-1:0] in_upper,
    input  logic [FLAG_W-1:0] in_flags,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [DATA_W-1:0] out_upper,
    output logic [FLAG_W-1:0] out_flags,
    output logic [FLAG_W-1:0] sticky_flags,
    input  logic              sticky_clr,
    output logic [1:0]        count,
    output logic              par_err
);

    // Storage: entries are intentionally not reset, only control state is.
    logic [DATA_W-1:0] result_mem [2];
    logic [DATA_W-1:0] upper_mem  [2];
    logic [FLAG_W-1:0] flags_mem  [2];

    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count_q;
    logic [FLAG_W-1:0] sticky_q;
    logic              push;
    logic              pop;

    // Handshake status depends only on the registered occupancy, so in_ready
    // never looks at out_ready and there is no combinational path through.
    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign count        = count_q;
    assign sticky_flags = sticky_q;

    // Head entry is read straight from storage: a word written at an edge
    // shows up on out_* only after that edge, never bypassed.
    assign out_result = result_mem[rd_ptr];
    assign out_upper  = upper_mem[rd_ptr];
    assign out_flags  = flags_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count_q  <= 2'd0;
            sticky_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
            // A clear and a push in the same cycle leave exactly the new flags.
            sticky_q <= (sticky_clr ? '0 : sticky_q) | (push ? in_flags : '0);
        end
    end

    // Writes are gated by rst_n so a word offered during reset leaves no trace.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            result_mem[wr_ptr] <= in_result;
            upper_mem[wr_ptr]  <= in_upper;
            flags_mem[wr_ptr]  <= in_flags;
        end
    end

`ifdef ALU_RB_PARITY_CHK_EN
    logic par_err_q;

    // The parity flag is expected to equal the XNOR reduction of the result.
    // Once set, the error is held until reset; sticky_clr does not touch it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            par_err_q <= 1'b0;
        end else if (push && ((~^in_result) != in_flags[4])) begin
            par_err_q <= 1'b1;
        end
    end

    assign par_err = par_err_q;
`else
    assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_buffer.sv
// ---------------------------------------------------------------------------
// tb_alu_result_buffer
//
// Purpose:
//   Self-checking bench for alu_result_buffer. A queue-based reference model
//   tracks what the buffer must hold; a compare process checks every output
//   against it on each falling edge. Directed sequences pin the model with
//   hand-computed literals, then a randomized phase exercises the handshake.
//
// Configuration macro:
//   ALU_RB_PARITY_CHK_EN  selects the expected par_err behaviour.
// ---------------------------------------------------------------------------
module tb_alu_result_buffer;

    localparam int DATA_W = 64;
    localparam int FLAG_W = 7;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_result;
    logic [DATA_W-1:0] in_upper;
    logic [FLAG_W-1:0] in_flags;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic [DATA_W-1:0] out_upper;
    logic [FLAG_W-1:0] out_flags;
    logic [FLAG_W-1:0] sticky_flags;
    logic              sticky_clr;
    logic [1:0]        count;
    logic              par_err;

    int compared   = 0;
    int mismatched = 0;

    alu_result_buffer #(
        .DATA_W(DATA_W),
        .FLAG_W(FLAG_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_result    (in_result),
        .in_upper     (in_upper),
        .in_flags     (in_flags),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_upper    (out_upper),
        .out_flags    (out_flags),
        .sticky_flags (sticky_flags),
        .sticky_clr   (sticky_clr),
        .count        (count),
        .par_err      (par_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the buffer contents are just an ordered queue.
    typedef struct {
        logic [DATA_W-1:0] r;
        logic [DATA_W-1:0] u;
        logic [FLAG_W-1:0] f;
    } entry_t;

    entry_t            model_q[$];
    logic [FLAG_W-1:0] model_sticky = '0;
    logic              model_par    = 1'b0;
    bit                model_known  = 1'b0;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Model update on each rising edge from the inputs the DUT also sees.
    always @(posedge clk) begin
        bit     do_push;
        bit     do_pop;
        entry_t e;
        if (!rst_n) begin
            model_q.delete();
            model_sticky = '0;
            model_par    = 1'b0;
            model_known  = 1'b1;
        end else if (model_known) begin
            do_push = in_valid && (model_q.size() < 2);
            do_pop  = out_ready && (model_q.size() > 0);
            if (do_pop) void'(model_q.pop_front());
            if (do_push) begin
                e.r = in_result;
                e.u = in_upper;
                e.f = in_flags;
                model_q.push_back(e);
            end
            if (sticky_clr) model_sticky = '0;
            if (do_push) model_sticky = model_sticky | in_flags;
`ifdef ALU_RB_PARITY_CHK_EN
            if (do_push && ((^in_result) == in_flags[4])) model_par = 1'b1;
`endif
        end
    end

    // Compare process: every output, every falling edge, once the model is known.
    always @(negedge clk) begin
        if (model_known) begin
            checkOutput("count", 64'(count), 64'(model_q.size()));
            checkOutput("out_valid", 64'(out_valid), 64'(model_q.size() != 0));
            checkOutput("in_ready", 64'(in_ready), 64'(model_q.size() != 2));
            checkOutput("sticky_flags", 64'(sticky_flags), 64'(model_sticky));
            checkOutput("par_err", 64'(par_err), 64'(model_par));
            if (model_q.size() != 0) begin
                checkOutput("out_result", out_result, model_q[0].r);
                checkOutput("out_upper", out_upper, model_q[0].u);
                checkOutput("out_flags", 64'(out_flags), 64'(model_q[0].f));
            end
        end
    end

    // Drive one cycle of inputs, then return shortly after the rising edge.
    task automatic applyStimulus(input logic rst_v, input logic iv,
                                 input logic [63:0] r, input logic [63:0] u,
                                 input logic [6:0] f, input logic ordy,
                                 input logic clr);
        rst_n      = rst_v;
        in_valid   = iv;
        in_result  = r;
        in_upper   = u;
        in_flags   = f;
        out_ready  = ordy;
        sticky_clr = clr;
        @(posedge clk);
        #1;
    endtask

    localparam logic [63:0] VA = 64'hA000_0000_0000_0001;
    localparam logic [63:0] VB = 64'hB000_0000_0000_0002;
    localparam logic [63:0] VC = 64'hC000_0000_0000_0003;
    localparam logic [63:0] VD = 64'hD000_0000_0000_0004;
    localparam logic [63:0] VX = 64'hE000_0000_0000_0005;

    initial begin
        logic [63:0] r;
        logic [63:0] u;
        logic [6:0]  f;

        rst_n = 1'b0; in_valid = 1'b0; in_result = '0; in_upper = '0;
        in_flags = '0; out_ready = 1'b0; sticky_clr = 1'b0;

        // Reset with a push offered: it must be dropped.
        applyStimulus(0, 1, 64'h77, 64'h0, 7'h7F, 0, 0);
        applyStimulus(0, 1, 64'h77, 64'h0, 7'h7F, 0, 0);
        @(negedge clk);
        checkOutput("rst_count", 64'(count), 64'd0);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
        checkOutput("rst_sticky", 64'(sticky_flags), 64'd0);

        // Single word through with consumer ready.
        applyStimulus(1, 1, 64'h5, 64'h0, 7'h00, 1, 0);
        @(negedge clk);
        checkOutput("one_valid", 64'(out_valid), 64'd1);
        checkOutput("one_result", out_result, 64'h5);
        checkOutput("one_count", 64'(count), 64'd1);
        applyStimulus(1, 0, 64'h0, 64'h0, 7'h00, 1, 0);
        @(negedge clk);
        checkOutput("one_drained", 64'(count), 64'd0);

        // Back-to-back A, B, C while consumer stalls; order must be kept.
        applyStimulus(1, 1, VA, ~VA, 7'h01, 0, 0);
        applyStimulus(1, 1, VB, ~VB, 7'h01, 0, 0);
        applyStimulus(1, 1, VC, ~VC, 7'h01, 0, 0);
        @(negedge clk);
        checkOutput("full_count", 64'(count), 64'd2);
        checkOutput("full_in_ready", 64'(in_ready), 64'd0);
        checkOutput("full_head_A", out_result, VA);
        checkOutput("full_head_A_upper", out_upper, ~VA);
        applyStimulus(1, 1, VC, ~VC, 7'h01, 1, 0);
        @(negedge clk);
        checkOutput("head_B", out_result, VB);
        checkOutput("after_popA_count", 64'(count), 64'd1);
        applyStimulus(1, 1, VC, ~VC, 7'h01, 1, 0);
        @(negedge clk);
        checkOutput("head_C", out_result, VC);
        checkOutput("pushpop_count", 64'(count), 64'd1);
        applyStimulus(1, 0, 64'h0, 64'h0, 7'h00, 1, 0);
        @(negedge clk);
        checkOutput("abc_drained", 64'(count), 64'd0);

        // Push and pop together at count 1.
        applyStimulus(1, 1, VX, 64'h0, 7'h01, 0, 0);
        applyStimulus(1, 1, VD, 64'h0, 7'h01, 1, 0);
        @(negedge clk);
        checkOutput("pp_count", 64'(count), 64'd1);
        checkOutput("pp_head_D", out_result, VD);
        applyStimulus(1, 0, 64'h0, 64'h0, 7'h00, 1, 0);

        // Sticky flags accumulate and clear-with-push keeps only the new flags.
        applyStimulus(1, 0, 64'h0, 64'h0, 7'h00, 1, 1);
        @(negedge clk);
        checkOutput("sticky_cleared", 64'(sticky_flags), 64'h00);
        applyStimulus(1, 1, 64'h1, 64'h0, 7'h01, 1, 0);
        applyStimulus(1, 1, 64'h1, 64'h0, 7'h04, 1, 0);
        @(negedge clk);
        checkOutput("sticky_05", 64'(sticky_flags), 64'h05);
        applyStimulus(1, 1, 64'h1, 64'h0, 7'h02, 1, 1);
        @(negedge clk);
        checkOutput("sticky_clr_push", 64'(sticky_flags), 64'h02);
        applyStimulus(1, 0, 64'h0, 64'h0, 7'h00, 1, 0);

        // Parity flag set while result 1 has odd parity.
        applyStimulus(1, 1, 64'h1, 64'h0, 7'h10, 1, 0);
        @(negedge clk);
`ifdef ALU_RB_PARITY_CHK_EN
        checkOutput("par_err_set", 64'(par_err), 64'd1);
`else
        checkOutput("par_err_off", 64'(par_err), 64'd0);
`endif
        applyStimulus(1, 0, 64'h0, 64'h0, 7'h00, 1, 1);
        @(negedge clk);
`ifdef ALU_RB_PARITY_CHK_EN
        checkOutput("par_err_hold", 64'(par_err), 64'd1);
`else
        checkOutput("par_err_off_clr", 64'(par_err), 64'd0);
`endif

        // Reset with the buffer full.
        applyStimulus(1, 1, VA, 64'h0, 7'h03, 0, 0);
        applyStimulus(1, 1, VB, 64'h0, 7'h03, 0, 0);
        @(negedge clk);
        checkOutput("pre_rst_count", 64'(count), 64'd2);
        applyStimulus(0, 1, VC, 64'h0, 7'h03, 1, 0);
        @(negedge clk);
        checkOutput("mid_rst_count", 64'(count), 64'd0);
        checkOutput("mid_rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("mid_rst_in_ready", 64'(in_ready), 64'd1);
        checkOutput("mid_rst_sticky", 64'(sticky_flags), 64'd0);
        checkOutput("mid_rst_par_err", 64'(par_err), 64'd0);

        // Randomized traffic with occasional resets and clears.
        for (int i = 0; i < 3000; i++) begin
            r = {$urandom, $urandom};
            u = {$urandom, $urandom};
            f = 7'($urandom);
            f[4] = (~^r) ^ ($urandom_range(0, 15) == 0);
            applyStimulus(($urandom_range(0, 99) != 0), 1'($urandom_range(0, 1)), r, u, f,
                          ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0));
        end
        applyStimulus(1, 0, 64'h0, 64'h0, 7'h00, 0, 0);
        @(negedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
